// File: rtl/issue_queue_pkg.sv
// Shared types for the collapsing issue queue: entries, dispatch requests,
// wakeup broadcasts and the source-capture helpers.
package issue_queue_pkg;

  localparam int XLEN          = 32;
  localparam int PREG_W        = 6;
  localparam int MACHINE_WIDTH = 2;
  localparam int ISSUE_WIDTH   = 2;
  localparam int ALU_NUM       = 2;
  localparam int QUEUE_LEN_DEF = 16;
  localparam int ISSUE_NUM_DEF = 1;
  localparam int WAKE_CH       = ISSUE_WIDTH + ALU_NUM;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [PREG_W-1:0] preg_addr_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t id;
    word_t      data;
  } src_data_t;

  typedef struct packed {
    logic [7:0] op;
    preg_addr_t dst;
    src_data_t  src1;
    src_data_t  src2;
  } entry_t;

  typedef struct packed {
    logic   valid;
    entry_t entry;
  } write_req_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t id;
    word_t      data;
  } wake_data_t;

  typedef wake_data_t [WAKE_CH-1:0] wake_vec_t;

  // Capture broadcast data into a waiting source; lowest channel wins.
  function automatic src_data_t src_wake(
    src_data_t s,
    wake_vec_t w
  );
    src_data_t r;
    r = s;
    for (int k = WAKE_CH - 1; k >= 0; k--) begin
      if (!s.valid && w[k].valid && w[k].id == s.id) begin
        r.valid = 1'b1;
        r.data  = w[k].data;
      end
    end
    return r;
  endfunction

  function automatic entry_t entry_wake(
    entry_t    e,
    wake_vec_t w
  );
    entry_t r;
    r      = e;
    r.src1 = src_wake(e.src1, w);
    r.src2 = src_wake(e.src2, w);
    return r;
  endfunction

endpackage

// File: rtl/issue_select.sv
// Oldest-first multi-grant picker over a compacted ready vector.
// Bit 0 is the oldest slot; grant i is the (i+1)-th set bit.
module issue_select
  #(
    parameter int N = 16,
    parameter int M = 1
  )
  (
    input  logic [N-1:0]        ready,
    output logic [M-1:0][N-1:0] grant,
    output logic [M-1:0]        valid
  );

  // Peel off the lowest set bit once per issue port.
  always_comb begin
    logic [N-1:0] rem;
    rem = ready;
    for (int i = 0; i < M; i++) begin
      grant[i] = rem & (~rem + N'(1));
      valid[i] = |rem;
      rem      = rem & ~grant[i];
    end
  end

endmodule

// File: rtl/issue_queue_collapse.sv
// Age-ordered collapsing issue queue with wakeup capture and flush.
// Optional macro ISSUE_QUEUE_WAKE_BYPASS_EN: same-cycle wake forwarding.
module issue_queue_collapse
  import issue_queue_pkg::*;
  #(
    parameter int QUEUE_LEN = QUEUE_LEN_DEF,
    parameter int WRITE_NUM = MACHINE_WIDTH,
    parameter int WAKE_NUM  = WAKE_CH,
    parameter int ISSUE_NUM = ISSUE_NUM_DEF
  )
  (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  write_req_t [WRITE_NUM-1:0]         write,
    output logic                               write_ready,
    input  wake_data_t [WAKE_NUM-1:0]          wake,
    output logic [ISSUE_NUM-1:0]               issue_valid,
    output entry_t [ISSUE_NUM-1:0]             issue_entry,
    input  logic [ISSUE_NUM-1:0]               issue_ready,
    output logic [$clog2(QUEUE_LEN+1)-1:0]     count
  );

  localparam int CW = $clog2(QUEUE_LEN + 1);
  localparam int AW = $clog2(QUEUE_LEN);
  localparam logic [CW-1:0] QL = CW'(QUEUE_LEN);
  localparam logic [CW-1:0] WN = CW'(WRITE_NUM);

  if (WRITE_NUM > QUEUE_LEN) begin : g_bad_write
    $error("WRITE_NUM exceeds QUEUE_LEN");
  end
  if (ISSUE_NUM > QUEUE_LEN) begin : g_bad_issue
    $error("ISSUE_NUM exceeds QUEUE_LEN");
  end
  if (QUEUE_LEN < 2) begin : g_bad_len
    $error("QUEUE_LEN must be at least 2");
  end
  if (WAKE_NUM != WAKE_CH) begin : g_bad_wake
    $error("WAKE_NUM must match the package wake channel count");
  end

  entry_t [QUEUE_LEN-1:0] q;
  entry_t [QUEUE_LEN-1:0] qw;
  entry_t [QUEUE_LEN-1:0] qs;
  entry_t [QUEUE_LEN-1:0] nq;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          ncnt;
  logic [QUEUE_LEN-1:0]   occ;
  logic [QUEUE_LEN-1:0]   rdy;
  logic [QUEUE_LEN-1:0]   fire;
  logic [ISSUE_NUM-1:0][QUEUE_LEN-1:0] gnt;
  logic [ISSUE_NUM-1:0]   gv;
  logic                   accept;

  // Occupancy mask and the post-wake view of every stored entry.
  always_comb begin
    for (int j = 0; j < QUEUE_LEN; j++) begin
      occ[j] = CW'(j) < cnt;
      qw[j]  = entry_wake(q[j], wake);
    end
  end

`ifdef ISSUE_QUEUE_WAKE_BYPASS_EN
  assign qs = qw;
`else
  assign qs = q;
`endif

  // An entry is ready once both sources hold data.
  always_comb begin
    for (int j = 0; j < QUEUE_LEN; j++) begin
      rdy[j] = occ[j] & qs[j].src1.valid & qs[j].src2.valid;
    end
  end

  issue_select #(
    .N (QUEUE_LEN),
    .M (ISSUE_NUM)
  ) u_sel (
    .ready (rdy),
    .grant (gnt),
    .valid (gv)
  );

  assign issue_valid = gv & {ISSUE_NUM{~flush}};
  assign write_ready = (QL - cnt) >= WN;
  assign accept      = write_ready & ~flush;
  assign count       = cnt;

  // Route each granted slot onto its issue port.
  always_comb begin
    for (int i = 0; i < ISSUE_NUM; i++) begin
      issue_entry[i] = '0;
      for (int j = 0; j < QUEUE_LEN; j++) begin
        if (gnt[i][j]) begin
          issue_entry[i] = issue_entry[i] | qs[j];
        end
      end
    end
  end

  // Slots consumed this cycle; grants may be non-contiguous.
  always_comb begin
    fire = '0;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      if (issue_valid[i] && issue_ready[i]) begin
        fire = fire | gnt[i];
      end
    end
  end

  // Collapse survivors toward slot 0, then append accepted writes.
  always_comb begin
    logic [CW-1:0] p;
    nq = q;
    p  = '0;
    for (int j = 0; j < QUEUE_LEN; j++) begin
      if (occ[j] && !fire[j]) begin
        nq[p[AW-1:0]] = qw[j];
        p = p + CW'(1);
      end
    end
    for (int w = 0; w < WRITE_NUM; w++) begin
      if (accept && write[w].valid) begin
        if (p < QL) begin
          nq[p[AW-1:0]] = entry_wake(write[w].entry, wake);
        end
        p = p + CW'(1);
      end
    end
    ncnt = flush ? '0 : p;
  end

  // Occupancy count; reset and flush empty the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= ncnt;
    end
  end

  // Entry storage; contents past count are don't-care.
  always_ff @(posedge clk) begin
    q <= nq;
  end

endmodule

// File: tb/tb_issue_queue_collapse.sv
// Bench for issue_queue_collapse: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_issue_queue_collapse;
  import issue_queue_pkg::*;

  localparam int QL = 16;
  localparam int WN = 2;
  localparam int KN = 4;
  localparam int IN = 2;
`ifdef ISSUE_QUEUE_WAKE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  write_req_t [WN-1:0]   write;
  logic                  write_ready;
  wake_data_t [KN-1:0]   wake;
  logic [IN-1:0]         issue_valid;
  entry_t [IN-1:0]       issue_entry;
  logic [IN-1:0]         issue_ready;
  logic [4:0]            count;

  always #5 clk = ~clk;

  issue_queue_collapse #(
    .QUEUE_LEN (QL),
    .WRITE_NUM (WN),
    .WAKE_NUM  (KN),
    .ISSUE_NUM (IN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .write       (write),
    .write_ready (write_ready),
    .wake        (wake),
    .issue_valid (issue_valid),
    .issue_entry (issue_entry),
    .issue_ready (issue_ready),
    .count       (count)
  );

  int errors = 0;
  int checks = 0;
  entry_t mq[$];
  int rdq[$];

  typedef struct {
    logic        w0v;
    logic        w0s1v;
    logic [5:0]  w0id;
    logic [7:0]  w0op;
    logic        w1v;
    logic [7:0]  w1op;
    logic        kv;
    logic [5:0]  kid;
    logic [31:0] kd;
    logic [1:0]  ird;
    logic [4:0]  ecnt;
    logic [1:0]  eiv;
    logic [7:0]  eop;
    logic [31:0] ed;
  } vec_t;

  vec_t tv[9];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic src_data_t bsrc(src_data_t s);
    src_data_t r;
    r = s;
    if (s.valid) return r;
    for (int k = 0; k < KN; k++) begin
      if (wake[k].valid && wake[k].id == s.id) begin
        r.valid = 1'b1;
        r.data  = wake[k].data;
        return r;
      end
    end
    return r;
  endfunction

  function automatic entry_t bent(entry_t e);
    entry_t r;
    r      = e;
    r.src1 = bsrc(e.src1);
    r.src2 = bsrc(e.src2);
    return r;
  endfunction

  function automatic entry_t pv(entry_t e);
    return BYP ? bent(e) : e;
  endfunction

  function automatic void build_rdy();
    entry_t e;
    rdq.delete();
    for (int j = 0; j < mq.size(); j++) begin
      e = pv(mq[j]);
      if (e.src1.valid && e.src2.valid) rdq.push_back(j);
    end
  endfunction

  function automatic entry_t mk(logic [7:0] op, logic s1v,
                                logic [5:0] s1id, logic [31:0] s1d);
    entry_t e;
    e.op   = op;
    e.dst  = op[5:0];
    e.src1 = '{valid: s1v, id: s1id, data: s1d};
    e.src2 = '{valid: 1'b1, id: 6'd1, data: 32'h2222};
    return e;
  endfunction

  task automatic model_check();
    bit ev;
    int sz;
    build_rdy();
    sz = mq.size();
    chk("count", 128'(count), 128'(sz));
    chk("write_ready", 128'(write_ready), 128'((QL - sz) >= WN));
    for (int i = 0; i < IN; i++) begin
      ev = !flush && (i < rdq.size());
      chk($sformatf("issue_valid%0d", i), 128'(issue_valid[i]), 128'(ev));
      if (ev) begin
        chk($sformatf("issue_entry%0d", i), 128'(issue_entry[i]),
            128'(pv(mq[rdq[i]])));
      end
    end
  endtask

  task automatic model_update();
    entry_t nq[$];
    bit fr[QL];
    bit acc;
    build_rdy();
    if (flush) begin
      mq.delete();
      return;
    end
    acc = (QL - int'(mq.size())) >= WN;
    for (int j = 0; j < QL; j++) fr[j] = 1'b0;
    for (int i = 0; i < IN; i++) begin
      if (i < rdq.size() && issue_ready[i]) fr[rdq[i]] = 1'b1;
    end
    for (int j = 0; j < mq.size(); j++) begin
      if (!fr[j]) nq.push_back(bent(mq[j]));
    end
    if (acc) begin
      for (int w = 0; w < WN; w++) begin
        if (write[w].valid) nq.push_back(bent(write[w].entry));
      end
    end
    mq = nq;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    write       = '0;
    wake        = '0;
    issue_ready = '0;
    flush       = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    sample();
    advance();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_wr", 128'(write_ready), 128'(1));
    chk("reset_iv", 128'(issue_valid), 128'(0));
    reset = 1'b0;
    mq.delete();

    tv[0] = '{1,1,0,8'd1, 1,8'd2, 0,0,0, 2'b01, 0, 2'b00, 0, 0};
    tv[1] = '{0,0,0,0, 0,0, 0,0,0, 2'b01, 2, 2'b11, 8'd1, 32'h1111};
    tv[2] = '{0,0,0,0, 0,0, 0,0,0, 2'b01, 1, 2'b01, 8'd2, 32'h1111};
    tv[3] = '{1,0,6'd5,8'd3, 0,0, 0,0,0, 2'b01, 0, 2'b00, 0, 0};
    tv[4] = '{0,0,0,0, 0,0, 1,6'd5,32'hDEADBEEF, 2'b00, 1,
              BYP ? 2'b01 : 2'b00, 8'd3, 32'hDEADBEEF};
    tv[5] = '{0,0,0,0, 0,0, 0,0,0, 2'b01, 1, 2'b01, 8'd3, 32'hDEADBEEF};
    tv[6] = '{1,0,6'd9,8'd4, 0,0, 1,6'd9,32'hCAFEF00D, 2'b01, 0, 2'b00,
              0, 0};
    tv[7] = '{0,0,0,0, 0,0, 0,0,0, 2'b01, 1, 2'b01, 8'd4, 32'hCAFEF00D};
    tv[8] = '{0,0,0,0, 0,0, 0,0,0, 2'b01, 0, 2'b00, 0, 0};

    for (int r = 0; r < 9; r++) begin
      idle();
      if (tv[r].w0v) begin
        write[0] = '{1'b1, mk(tv[r].w0op, tv[r].w0s1v, tv[r].w0id,
                              tv[r].w0s1v ? 32'h1111 : 32'h0)};
      end
      if (tv[r].w1v) write[1] = '{1'b1, mk(tv[r].w1op, 1'b1, 6'd2, 32'h1111)};
      wake[0]     = '{tv[r].kv, tv[r].kid, tv[r].kd};
      issue_ready = tv[r].ird;
      sample();
      chk($sformatf("row%0d_count", r), 128'(count), 128'(tv[r].ecnt));
      chk($sformatf("row%0d_iv", r), 128'(issue_valid), 128'(tv[r].eiv));
      if (tv[r].eiv[0]) begin
        chk($sformatf("row%0d_op", r), 128'(issue_entry[0].op),
            128'(tv[r].eop));
        chk($sformatf("row%0d_data", r), 128'(issue_entry[0].src1.data),
            128'(tv[r].ed));
      end
      advance();
    end

    idle();
    write[0] = '{1'b1, mk(8'd10, 1'b1, 6'd3, 32'h10)};
    write[1] = '{1'b1, mk(8'd11, 1'b0, 6'd62, 32'h0)};
    sample();
    advance();
    for (int c = 0; c < 6; c++) begin
      write[0] = '{1'b1, mk(8'd12, 1'b0, 6'd62, 32'h0)};
      write[1] = '{1'b1, mk(8'd12, 1'b0, 6'd62, 32'h0)};
      sample();
      advance();
    end
    write[1] = '0;
    write[0] = '{1'b1, mk(8'd13, 1'b0, 6'd62, 32'h0)};
    sample();
    advance();
    write[0] = '{1'b1, mk(8'd14, 1'b1, 6'd3, 32'h14)};
    write[1] = '{1'b1, mk(8'd14, 1'b1, 6'd3, 32'h14)};
    sample();
    chk("full_count", 128'(count), 128'(15));
    chk("full_wr", 128'(write_ready), 128'(0));
    chk("full_iv", 128'(issue_valid), 128'(2'b01));
    advance();
    idle();
    issue_ready = 2'b01;
    sample();
    chk("full_hold_count", 128'(count), 128'(15));
    advance();
    idle();
    sample();
    chk("after_issue_count", 128'(count), 128'(14));
    chk("after_issue_wr", 128'(write_ready), 128'(1));
    advance();
    do_flush();

    idle();
    write[0] = '{1'b1, mk(8'd20, 1'b0, 6'd61, 32'h0)};
    write[1] = '{1'b1, mk(8'd21, 1'b1, 6'd3, 32'h21)};
    sample();
    advance();
    idle();
    write[0] = '{1'b1, mk(8'd22, 1'b1, 6'd3, 32'h22)};
    sample();
    advance();
    idle();
    issue_ready = 2'b10;
    sample();
    chk("nc_count", 128'(count), 128'(3));
    chk("nc_iv", 128'(issue_valid), 128'(2'b11));
    chk("nc_slot0", 128'(issue_entry[0].op), 128'(21));
    chk("nc_slot1", 128'(issue_entry[1].op), 128'(22));
    advance();
    idle();
    sample();
    chk("nc_after_count", 128'(count), 128'(2));
    chk("nc_after_iv", 128'(issue_valid), 128'(2'b01));
    chk("nc_after_slot0", 128'(issue_entry[0].op), 128'(21));
    advance();
    do_flush();

    for (int c = 0; c < 4; c++) begin
      idle();
      write[0] = '{1'b1, mk(8'd30, 1'b1, 6'd3, 32'h30)};
      write[1] = '{1'b1, mk(8'd30, 1'b1, 6'd3, 32'h30)};
      sample();
      advance();
    end
    write[0] = '{1'b1, mk(8'h77, 1'b1, 6'd3, 32'h77)};
    write[1] = '{1'b1, mk(8'h77, 1'b1, 6'd3, 32'h77)};
    flush = 1'b1;
    issue_ready = 2'b11;
    sample();
    chk("flush_pre_count", 128'(count), 128'(8));
    chk("flush_iv", 128'(issue_valid), 128'(0));
    advance();
    idle();
    issue_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("flush_post_count", 128'(count), 128'(0));
      chk("flush_post_iv", 128'(issue_valid), 128'(0));
      advance();
    end

    idle();
    write[0] = '{1'b1, mk(8'd40, 1'b1, 6'd3, 32'h40)};
    write[1] = '{1'b1, mk(8'd41, 1'b1, 6'd3, 32'h41)};
    sample();
    advance();
    issue_ready = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_count", 128'(count), 128'(0));
    chk("midreset_iv", 128'(issue_valid), 128'(0));
    chk("midreset_wr", 128'(write_ready), 128'(1));
    mq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();

    for (int c = 0; c < 3000; c++) begin
      idle();
      for (int w = 0; w < WN; w++) begin
        write[w].valid = 1'($urandom_range(0, 1));
        write[w].entry.op = 8'($urandom);
        write[w].entry.dst = 6'($urandom);
        write[w].entry.src1 = '{1'($urandom_range(0, 1)),
                                6'($urandom_range(0, 7)), $urandom};
        write[w].entry.src2 = '{1'($urandom_range(0, 1)),
                                6'($urandom_range(0, 7)), $urandom};
      end
      for (int k = 0; k < KN; k++) begin
        wake[k] = '{($urandom_range(0, 2) == 0),
                    6'($urandom_range(0, 7)), $urandom};
      end
      issue_ready = 2'($urandom);
      flush = ($urandom_range(0, 49) == 0);
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
